// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use/branch/dmem-wait stall and flush control for the 5-stage core
// Optional stall_cycles performance counter enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       addr_a,
  input  logic [4:0]       addr_b,
  input  logic             uses_a,
  input  logic             uses_b,
  input  logic [4:0]       dest_ex,
  input  logic             memrd_ex,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_wr_en,
  output logic             ifid_wr_en,
  output logic             idex_wr_en,
  output logic             exmem_wr_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam state_t     BR_STATE     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       pend_q, pend_d;
  logic       load_use;

  // X31 is the zero/discard register, so it never carries a dependency.
  assign load_use = memrd_ex && (dest_ex != 5'd31) &&
                    ((uses_a && (addr_a == dest_ex)) || (uses_b && (addr_b == dest_ex)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pend_d      = pend_q;
    pc_wr_en    = 1'b1;
    ifid_wr_en  = 1'b1;
    idex_wr_en  = 1'b1;
    exmem_wr_en = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    if (dmem_busy) begin
      // Whole pipe freezes; a branch resolved meanwhile is remembered for the release cycle.
      pc_wr_en    = 1'b0;
      ifid_wr_en  = 1'b0;
      idex_wr_en  = 1'b0;
      exmem_wr_en = 1'b0;
      state_d     = MEM_WAIT;
      if (branch_taken) pend_d = 1'b1;
    end else begin
      unique case (state_q)
        RUN, MEM_WAIT: begin
          if (branch_taken || (state_q == MEM_WAIT && (pend_q || flush_cnt_q != 3'd0))) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pend_d      = 1'b0;
            state_d     = BR_STATE;
            flush_cnt_d = FLUSH_RELOAD;
          end else begin
            state_d = RUN;
            if (load_use) begin
              pc_wr_en    = 1'b0;
              ifid_wr_en  = 1'b0;
              idex_bubble = 1'b1;
            end
          end
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (branch_taken) begin
            state_d     = BR_STATE;
            flush_cnt_d = FLUSH_RELOAD;
          end else if (flush_cnt_q <= 3'd1) begin
            state_d     = RUN;
            flush_cnt_d = 3'd0;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end

    if (!reset_n) begin
      pc_wr_en    = 1'b0;
      ifid_wr_en  = 1'b0;
      idex_wr_en  = 1'b0;
      exmem_wr_en = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!pc_wr_en && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - vector-table bench for hazard_stall_ctrl (FLUSH_CYCLES=3, CNT_W=4)
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {pc, ifid, idex, exmem, flush, bubble}
  localparam logic [5:0] DEF = 6'b1111_00;
  localparam logic [5:0] STL = 6'b0011_01;
  localparam logic [5:0] BRF = 6'b1111_11;
  localparam logic [5:0] FRZ = 6'b0000_00;

  typedef struct {
    string      name;
    logic [4:0] aa, ab;
    logic       ua, ub;
    logic [4:0] dex;
    logic       mrd, bt, busy;
    logic [5:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] addr_a, addr_b, dest_ex;
  logic       uses_a, uses_b, memrd_ex, branch_taken, dmem_busy;
  logic       pc_wr_en, ifid_wr_en, idex_wr_en, exmem_wr_en, ifid_flush, idex_bubble;
  logic [3:0] stall_cycles;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  hazard_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .addr_a(addr_a), .addr_b(addr_b), .uses_a(uses_a), .uses_b(uses_b),
    .dest_ex(dest_ex), .memrd_ex(memrd_ex), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_wr_en(pc_wr_en), .ifid_wr_en(ifid_wr_en), .idex_wr_en(idex_wr_en),
    .exmem_wr_en(exmem_wr_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic add(input string n, input logic [4:0] aa, input logic [4:0] ab,
                     input logic ua, input logic ub, input logic [4:0] dex,
                     input logic mrd, input logic bt, input logic busy, input logic [5:0] exp);
    vec_t v;
    v.name = n; v.aa = aa; v.ab = ab; v.ua = ua; v.ub = ub;
    v.dex = dex; v.mrd = mrd; v.bt = bt; v.busy = busy; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic chk_out(input string n, input logic [5:0] exp);
    logic [5:0] got;
    got = {pc_wr_en, ifid_wr_en, idex_wr_en, exmem_wr_en, ifid_flush, idex_bubble};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", n, got, exp);
    end
  endtask

  task automatic chk_cnt(input string n, input logic [3:0] exp);
    checks++;
    if (stall_cycles !== exp) begin
      errors++;
      $display("FAIL %s: stall_cycles got %0d expected %0d", n, stall_cycles, exp);
    end
  endtask

  task automatic step(input string n, input logic [4:0] aa, input logic [4:0] ab,
                      input logic ua, input logic ub, input logic [4:0] dex,
                      input logic mrd, input logic bt, input logic busy, input logic [5:0] exp);
    @(negedge clk);
    addr_a = aa; addr_b = ab; uses_a = ua; uses_b = ub;
    dest_ex = dex; memrd_ex = mrd; branch_taken = bt; dmem_busy = busy;
    #1;
    chk_out(n, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    addr_a = '0; addr_b = '0; uses_a = 0; uses_b = 0;
    dest_ex = '0; memrd_ex = 0; branch_taken = 0; dmem_busy = 0;

    //   name         aa  ab ua ub dex mrd bt busy exp
    add("idle",       0,  0, 0, 0, 0,  0,  0, 0,   DEF);
    add("lu_a",       5,  0, 1, 0, 5,  1,  0, 0,   STL);
    add("lu_after",   5,  0, 1, 0, 0,  0,  0, 0,   DEF);
    add("x31",        0, 31, 0, 1, 31, 1,  0, 0,   DEF);
    add("no_read",    3,  0, 0, 0, 3,  1,  0, 0,   DEF);
    add("br_lu",      5,  0, 1, 0, 5,  1,  1, 0,   BRF);
    add("flush_2",    0,  0, 0, 0, 0,  0,  0, 0,   BRF);
    add("flush_3",    0,  0, 0, 0, 0,  0,  0, 0,   BRF);
    add("run_again",  0,  0, 0, 0, 0,  0,  0, 0,   DEF);
    add("busy_1",     0,  0, 0, 0, 0,  0,  0, 1,   FRZ);
    add("busy_2_br",  0,  0, 0, 0, 0,  0,  1, 1,   FRZ);
    add("busy_3",     0,  0, 0, 0, 0,  0,  0, 1,   FRZ);
    add("busy_4",     0,  0, 0, 0, 0,  0,  0, 1,   FRZ);
    add("release_br", 0,  0, 0, 0, 0,  0,  0, 0,   BRF);
    add("rel_flush2", 0,  0, 0, 0, 0,  0,  0, 0,   BRF);
    add("rel_flush3", 0,  0, 0, 0, 0,  0,  0, 0,   BRF);
    add("rel_run",    0,  0, 0, 0, 0,  0,  0, 0,   DEF);

    @(negedge clk);
    @(negedge clk);
    chk_out("in_reset", FRZ);
    chk_cnt("in_reset_cnt", 4'd0);
    reset_n = 1'b1;

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].aa, tbl[i].ab, tbl[i].ua, tbl[i].ub,
           tbl[i].dex, tbl[i].mrd, tbl[i].bt, tbl[i].busy, tbl[i].exp);
    chk_cnt("cnt_after_t1_t4", PERF ? 4'd5 : 4'd0);

    // Flush interrupted by dmem_busy restarts a full flush on release
    step("pre_br",     0, 0, 0, 0, 0, 0, 1, 0, BRF);
    step("pre_busy",   0, 0, 0, 0, 0, 0, 0, 1, FRZ);
    step("pre_rel",    0, 0, 0, 0, 0, 0, 0, 0, BRF);
    step("pre_f2",     0, 0, 0, 0, 0, 0, 0, 0, BRF);
    step("pre_f3",     0, 0, 0, 0, 0, 0, 0, 0, BRF);
    step("pre_run",    0, 0, 0, 0, 0, 0, 0, 0, DEF);

    step("lu_b",       1, 7, 0, 1, 7, 1, 0, 0, STL);
    step("lu_b_after", 1, 7, 0, 1, 7, 0, 0, 0, DEF);
    chk_cnt("cnt_7", PERF ? 4'd7 : 4'd0);

    // Long wait saturates the 4-bit counter; release with no pending flush sees load_use
    for (int k = 0; k < 10; k++) step("sat_busy", 0, 0, 0, 0, 0, 0, 0, 1, FRZ);
    chk_cnt("cnt_sat", PERF ? 4'd15 : 4'd0);
    step("rel_lu",     9, 0, 1, 0, 9, 1, 0, 0, STL);
    step("rel_lu_end", 9, 0, 1, 0, 9, 0, 0, 0, DEF);
    chk_cnt("cnt_hold", PERF ? 4'd15 : 4'd0);

    // Reset in MEM_WAIT with a pending flush clears everything
    step("mw_busy",    0, 0, 0, 0, 0, 0, 0, 1, FRZ);
    step("mw_br",      0, 0, 0, 0, 0, 0, 1, 1, FRZ);
    @(negedge clk);
    branch_taken = 0;
    reset_n = 1'b0;
    #1;
    chk_out("mid_reset", FRZ);
    chk_cnt("mid_reset_cnt", 4'd0);
    @(negedge clk);
    dmem_busy = 0;
    reset_n = 1'b1;
    #1;
    chk_out("post_reset_run", DEF);
    step("post_reset_2", 0, 0, 0, 0, 0, 0, 0, 0, DEF);
    chk_cnt("post_reset_cnt", 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
